wb_commit_stage: RTL and testbench
==================================

Name: wb_commit_stage

Overview:
- Writeback/commit stage directly downstream of the EXE/WB pipeline latch.
- Consumes the latched instruction and produces:
  - the integer register-file write port;
  - CSR access sequencing;
  - exception trap hand-off with PC redirect;
  - the retired-instruction counter.
- Drives the latch's lock and flush inputs so a multi-cycle CSR access or trap holds or kills the pipeline.

Parameters:
XLEN, 64, data/CSR width
PADDR, 40, PC and memory address width
INSTRET_W, 64, retired-instruction counter width

Ports:
CLK  in  1  clock; all state updates on rising edge
RST  in  1  reset; asynchronous, active-high
PC_VALID_WB  in  1  latch holds a valid instruction
PC_WB  in  PADDR  instruction PC
INST_WB  in  32  instruction word; [31:20]=CSR address, [11:7]=rd
WE_WB  in  1  integer rd write request
DATA_WB  in  XLEN  ALU/load result; also the CSR write operand
ADDR_WB  in  5  rd index
CSR_EN_WB  in  1  instruction is a CSR access
XCPT_WB  in  1  instruction raised an exception
XCPT_CAUSE_WB  in  XLEN  exception cause
REQ_ADDR_WB  in  PADDR  data-memory request address
RF_WE  out  1  register-file write enable
RF_WADDR  out  5  register-file write index
RF_WDATA  out  XLEN  register-file write data
CSR_REQ_VALID  out  1  CSR access request
CSR_REQ_ADDR  out  12  CSR address
CSR_REQ_WDATA  out  XLEN  CSR write operand
CSR_REQ_READY  in  1  CSR unit accepts the request and returns read data
CSR_RDATA  in  XLEN  old CSR value, written to rd
TRAP_VALID  out  1  trap request to CSR unit
TRAP_CAUSE  out  XLEN  registered cause
TRAP_EPC  out  PADDR  registered faulting PC
TRAP_TVAL  out  XLEN  registered trap value
TRAP_ACK  in  1  CSR unit accepted the trap
TRAP_VECTOR  in  PADDR  handler address, valid with TRAP_ACK
REDIRECT_VALID  out  1  fetch redirect pulse
REDIRECT_PC  out  PADDR  redirect target
PIPE_LOCK  out  1  drives the EXE/WB latch lock
PIPE_FLUSH  out  1  flushes all upstream stages
INSTRET  out  INSTRET_W  retired-instruction count

Behaviour:
Reset:
- RST high asynchronously forces state IDLE; INSTRET, TRAP_* and REDIRECT_PC registers clear to 0.
- With no valid instruction, every combinational output is 0.
- Reset mid-CSR or mid-trap abandons the operation; no retire is counted.

FSM states: IDLE, CSR_WAIT, TRAP_WAIT, REDIRECT.

IDLE, invalid cycle (PC_VALID_WB=0): all outputs 0.

IDLE, normal instruction (valid, no exception, no CSR):
- RF_WE = WE_WB & (ADDR_WB!=0); RF_WADDR=ADDR_WB; RF_WDATA=DATA_WB. Combinational, zero latency.
- INSTRET+1 at the next edge.

IDLE, exception (valid & XCPT_WB; has priority over CSR_EN_WB):
- No RF write, no retire.
- PIPE_LOCK=1 combinationally.
- Capture TRAP_CAUSE=XCPT_CAUSE_WB and TRAP_EPC=PC_WB.
- TRAP_TVAL = zero-extended REQ_ADDR_WB if cause is in 4..7, else 0.
- Next state TRAP_WAIT.

IDLE, CSR access (valid & CSR_EN_WB, no exception):
- PIPE_LOCK=1; CSR_REQ_VALID=1; CSR_REQ_ADDR=INST_WB[31:20]; CSR_REQ_WDATA=DATA_WB.
- READY in the same cycle completes as in CSR_WAIT, with no state change; otherwise next state CSR_WAIT.

CSR_WAIT:
- Request held stable; the latch is locked, so its inputs are stable.
- PIPE_LOCK = ~CSR_REQ_READY.
- On READY:
  - RF write of CSR_RDATA to rd if rd!=0;
  - INSTRET+1;
  - CSR_REQ_VALID still 1 that cycle;
  - next state IDLE.

TRAP_WAIT:
- TRAP_VALID=1; PIPE_LOCK=1.
- On TRAP_ACK, register TRAP_VECTOR into REDIRECT_PC and go to REDIRECT.

REDIRECT (exactly one cycle):
- REDIRECT_VALID=1; PIPE_FLUSH=1; PIPE_LOCK=0; TRAP_VALID=0.
- Next state IDLE; the flushed latch presents a bubble.

Other rules:
- TRAP_VALID and CSR_REQ_VALID are never both 1.
- INSTRET wraps modulo 2^INSTRET_W.

Decomposition:
- Shared package:
  - wb_state_t enum;
  - PADDR/XLEN constants;
  - CSR-address field slice constants;
  - misaligned/access-fault cause range constants (4..7).
- Sub-module wb_trap_ctrl holds the TRAP_WAIT/REDIRECT sequencing and the trap registers.
- Datapath muxing and INSTRET stay in the top module.

Test Plan:
- ALU op: valid, WE=1, rd=5, data=0x1234 -> RF_WE=1, RF_WADDR=5, RF_WDATA=0x1234 same cycle; INSTRET 0->1.
- x0 write: rd=0, WE=1 -> RF_WE=0; INSTRET still increments.
- CSR access: CSR_EN, INST[31:20]=0x300, READY delayed 3 cycles, CSR_RDATA=0xAB -> PIPE_LOCK high 3 cycles then released; one RF write of 0xAB; INSTRET +1 once.
- Load misaligned: XCPT, cause=4, REQ_ADDR=0x1003, PC=0x8000, ACK after 2 cycles with vector 0x100 -> TRAP_TVAL=0x1003, TRAP_EPC=0x8000, no RF write; then one-cycle REDIRECT_VALID + PIPE_FLUSH with REDIRECT_PC=0x100; INSTRET unchanged.
- Exception with CSR_EN also set -> trap path taken, CSR_REQ_VALID never asserted.
- RST asserted mid-CSR_WAIT -> state IDLE immediately; all outputs 0; INSTRET=0.

Source files
------------

// File: rtl/wb_commit_stage_pkg.sv
// Shared types and constants for the writeback/commit stage.
package wb_commit_stage_pkg;

  localparam int WB_XLEN      = 64;
  localparam int WB_PADDR     = 40;
  localparam int WB_INSTRET_W = 64;

  localparam int CSR_ADDR_MSB = 31;
  localparam int CSR_ADDR_LSB = 20;

  // Misaligned / access-fault causes carry the faulting data address as tval.
  localparam int CAUSE_TVAL_LO = 4;
  localparam int CAUSE_TVAL_HI = 7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CSR_WAIT,
    ST_TRAP_WAIT,
    ST_REDIRECT
  } wb_state_t;

endpackage

// File: rtl/wb_commit_stage_trap_ctrl.sv
// Trap hand-off sequencer: captures trap registers, waits for the CSR unit's
// acknowledge, then issues a single-cycle redirect/flush.
//   state        | meaning
//   ST_IDLE      | no trap in flight
//   ST_TRAP_WAIT | trap presented to CSR unit, pipeline locked
//   ST_REDIRECT  | one-cycle fetch redirect and upstream flush
module wb_trap_ctrl
  import wb_commit_stage_pkg::*;
#(
  parameter int XLEN  = WB_XLEN,
  parameter int PADDR = WB_PADDR
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trap_start,
  input  logic [XLEN-1:0]  cause_in,
  input  logic [PADDR-1:0] epc_in,
  input  logic [PADDR-1:0] req_addr_in,
  input  logic             trap_ack,
  input  logic [PADDR-1:0] trap_vector,
  output logic             busy,
  output logic             trap_valid,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  trap_cause,
  output logic [PADDR-1:0] trap_epc,
  output logic [XLEN-1:0]  trap_tval,
  output logic [PADDR-1:0] redirect_pc
);

  wb_state_t        state_q, state_d;
  logic [XLEN-1:0]  cause_q, cause_d;
  logic [PADDR-1:0] epc_q, epc_d;
  logic [XLEN-1:0]  tval_q, tval_d;
  logic [PADDR-1:0] redir_q, redir_d;
  logic             has_tval;

  assign has_tval = (cause_in >= XLEN'(CAUSE_TVAL_LO)) && (cause_in <= XLEN'(CAUSE_TVAL_HI));

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    epc_d   = epc_q;
    tval_d  = tval_q;
    redir_d = redir_q;
    case (state_q)
      ST_IDLE: begin
        if (trap_start) begin
          state_d = ST_TRAP_WAIT;
          cause_d = cause_in;
          epc_d   = epc_in;
          tval_d  = has_tval ? XLEN'(req_addr_in) : '0;
        end
      end
      ST_TRAP_WAIT: begin
        if (trap_ack) begin
          redir_d = trap_vector;
          state_d = ST_REDIRECT;
        end
      end
      ST_REDIRECT: state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cause_q <= '0;
      epc_q   <= '0;
      tval_q  <= '0;
      redir_q <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      epc_q   <= epc_d;
      tval_q  <= tval_d;
      redir_q <= redir_d;
    end
  end

  assign busy           = (state_q != ST_IDLE);
  assign trap_valid     = (state_q == ST_TRAP_WAIT);
  assign redirect_valid = (state_q == ST_REDIRECT);
  assign trap_cause     = cause_q;
  assign trap_epc       = epc_q;
  assign trap_tval      = tval_q;
  assign redirect_pc    = redir_q;

endmodule

// File: rtl/wb_commit_stage.sv
// Writeback/commit stage: RF write port, CSR access sequencing, trap hand-off
// and retired-instruction counting for the EXE/WB latch.
//   state        | meaning
//   ST_IDLE      | accepting the latched instruction
//   ST_CSR_WAIT  | CSR request outstanding, latch locked until ready
//   (trap states live in wb_trap_ctrl)
module wb_commit_stage
  import wb_commit_stage_pkg::*;
#(
  parameter int XLEN      = WB_XLEN,
  parameter int PADDR     = WB_PADDR,
  parameter int INSTRET_W = WB_INSTRET_W
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 PC_VALID_WB,
  input  logic [PADDR-1:0]     PC_WB,
  input  logic [31:0]          INST_WB,
  input  logic                 WE_WB,
  input  logic [XLEN-1:0]      DATA_WB,
  input  logic [4:0]           ADDR_WB,
  input  logic                 CSR_EN_WB,
  input  logic                 XCPT_WB,
  input  logic [XLEN-1:0]      XCPT_CAUSE_WB,
  input  logic [PADDR-1:0]     REQ_ADDR_WB,
  output logic                 RF_WE,
  output logic [4:0]           RF_WADDR,
  output logic [XLEN-1:0]      RF_WDATA,
  output logic                 CSR_REQ_VALID,
  output logic [11:0]          CSR_REQ_ADDR,
  output logic [XLEN-1:0]      CSR_REQ_WDATA,
  input  logic                 CSR_REQ_READY,
  input  logic [XLEN-1:0]      CSR_RDATA,
  output logic                 TRAP_VALID,
  output logic [XLEN-1:0]      TRAP_CAUSE,
  output logic [PADDR-1:0]     TRAP_EPC,
  output logic [XLEN-1:0]      TRAP_TVAL,
  input  logic                 TRAP_ACK,
  input  logic [PADDR-1:0]     TRAP_VECTOR,
  output logic                 REDIRECT_VALID,
  output logic [PADDR-1:0]     REDIRECT_PC,
  output logic                 PIPE_LOCK,
  output logic                 PIPE_FLUSH,
  output logic [INSTRET_W-1:0] INSTRET
);

  wb_state_t             state_q, state_d;
  logic [INSTRET_W-1:0]  instret_q, instret_d;
  logic                  trap_busy, trap_valid, redirect_valid;
  logic                  instr, xcpt_go, csr_go, norm, csr_act, csr_done, retire;
  logic                  rd_nz;
  logic                  unused_inst;

  assign unused_inst = ^{INST_WB[19:0]};

  // Gating with RST keeps every output quiet while reset is held.
  assign instr    = PC_VALID_WB & ~RST & ~trap_busy & (state_q == ST_IDLE);
  assign xcpt_go  = instr & XCPT_WB;
  assign csr_go   = instr & ~XCPT_WB & CSR_EN_WB;
  assign norm     = instr & ~XCPT_WB & ~CSR_EN_WB;
  assign csr_act  = csr_go | (state_q == ST_CSR_WAIT);
  assign csr_done = csr_act & CSR_REQ_READY;
  assign retire   = norm | csr_done;
  assign rd_nz    = (ADDR_WB != 5'd0);

  wb_trap_ctrl #(.XLEN(XLEN), .PADDR(PADDR)) u_trap (
    .clk            (CLK),
    .rst            (RST),
    .trap_start     (xcpt_go),
    .cause_in       (XCPT_CAUSE_WB),
    .epc_in         (PC_WB),
    .req_addr_in    (REQ_ADDR_WB),
    .trap_ack       (TRAP_ACK),
    .trap_vector    (TRAP_VECTOR),
    .busy           (trap_busy),
    .trap_valid     (trap_valid),
    .redirect_valid (redirect_valid),
    .trap_cause     (TRAP_CAUSE),
    .trap_epc       (TRAP_EPC),
    .trap_tval      (TRAP_TVAL),
    .redirect_pc    (REDIRECT_PC)
  );

  always_comb begin
    state_d   = state_q;
    instret_d = instret_q;
    case (state_q)
      ST_IDLE:     if (csr_go && !CSR_REQ_READY) state_d = ST_CSR_WAIT;
      ST_CSR_WAIT: if (CSR_REQ_READY) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
    if (retire) instret_d = instret_q + INSTRET_W'(1);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    RF_WE         = ((norm & WE_WB) | csr_done) & rd_nz;
    RF_WADDR      = (norm | csr_done) ? ADDR_WB : 5'd0;
    RF_WDATA      = '0;
    if (norm)          RF_WDATA = DATA_WB;
    else if (csr_done) RF_WDATA = CSR_RDATA;
    CSR_REQ_VALID = csr_act;
    CSR_REQ_ADDR  = csr_act ? INST_WB[CSR_ADDR_MSB:CSR_ADDR_LSB] : 12'd0;
    CSR_REQ_WDATA = csr_act ? DATA_WB : '0;
    TRAP_VALID     = trap_valid;
    REDIRECT_VALID = redirect_valid;
    PIPE_FLUSH     = redirect_valid;
    PIPE_LOCK      = xcpt_go | (csr_act & ~CSR_REQ_READY) | trap_valid;
  end

  assign INSTRET = instret_q;

endmodule

// File: tb/tb_wb_commit_stage.sv
// Directed bench for wb_commit_stage with an RF-write scoreboard.
module tb_wb_commit_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic        PC_VALID_WB;
  logic [39:0] PC_WB;
  logic [31:0] INST_WB;
  logic        WE_WB;
  logic [63:0] DATA_WB;
  logic [4:0]  ADDR_WB;
  logic        CSR_EN_WB;
  logic        XCPT_WB;
  logic [63:0] XCPT_CAUSE_WB;
  logic [39:0] REQ_ADDR_WB;
  logic        RF_WE;
  logic [4:0]  RF_WADDR;
  logic [63:0] RF_WDATA;
  logic        CSR_REQ_VALID;
  logic [11:0] CSR_REQ_ADDR;
  logic [63:0] CSR_REQ_WDATA;
  logic        CSR_REQ_READY;
  logic [63:0] CSR_RDATA;
  logic        TRAP_VALID;
  logic [63:0] TRAP_CAUSE;
  logic [39:0] TRAP_EPC;
  logic [63:0] TRAP_TVAL;
  logic        TRAP_ACK;
  logic [39:0] TRAP_VECTOR;
  logic        REDIRECT_VALID;
  logic [39:0] REDIRECT_PC;
  logic        PIPE_LOCK;
  logic        PIPE_FLUSH;
  logic [63:0] INSTRET;

  wb_commit_stage dut (
    .CLK(CLK), .RST(RST), .PC_VALID_WB(PC_VALID_WB), .PC_WB(PC_WB), .INST_WB(INST_WB),
    .WE_WB(WE_WB), .DATA_WB(DATA_WB), .ADDR_WB(ADDR_WB), .CSR_EN_WB(CSR_EN_WB),
    .XCPT_WB(XCPT_WB), .XCPT_CAUSE_WB(XCPT_CAUSE_WB), .REQ_ADDR_WB(REQ_ADDR_WB),
    .RF_WE(RF_WE), .RF_WADDR(RF_WADDR), .RF_WDATA(RF_WDATA),
    .CSR_REQ_VALID(CSR_REQ_VALID), .CSR_REQ_ADDR(CSR_REQ_ADDR), .CSR_REQ_WDATA(CSR_REQ_WDATA),
    .CSR_REQ_READY(CSR_REQ_READY), .CSR_RDATA(CSR_RDATA),
    .TRAP_VALID(TRAP_VALID), .TRAP_CAUSE(TRAP_CAUSE), .TRAP_EPC(TRAP_EPC), .TRAP_TVAL(TRAP_TVAL),
    .TRAP_ACK(TRAP_ACK), .TRAP_VECTOR(TRAP_VECTOR),
    .REDIRECT_VALID(REDIRECT_VALID), .REDIRECT_PC(REDIRECT_PC),
    .PIPE_LOCK(PIPE_LOCK), .PIPE_FLUSH(PIPE_FLUSH), .INSTRET(INSTRET)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [4:0]  a;
    logic [63:0] d;
  } rfw_t;

  rfw_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [63:0] exp_ir = 64'd0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [39:0] pc, input logic [31:0] inst,
                       input logic we, input logic [63:0] d, input logic [4:0] a,
                       input logic csr, input logic x, input logic [63:0] cause,
                       input logic [39:0] req);
    PC_VALID_WB = v; PC_WB = pc; INST_WB = inst; WE_WB = we; DATA_WB = d; ADDR_WB = a;
    CSR_EN_WB = csr; XCPT_WB = x; XCPT_CAUSE_WB = cause; REQ_ADDR_WB = req;
  endtask

  task automatic push(input logic [4:0] a, input logic [63:0] d);
    rfw_t e;
    e.a = a;
    e.d = d;
    sb.push_back(e);
  endtask

  // Scoreboard consumer plus the trap/CSR exclusivity check.
  always @(negedge CLK) begin
    rfw_t e;
    chk("trap_csr_excl", {63'd0, TRAP_VALID & CSR_REQ_VALID}, 64'd0);
    if (RF_WE === 1'b1) begin
      if (sb.size() == 0) begin
        chk("rf_unexpected_we", {63'd0, RF_WE}, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("rf_waddr", {59'd0, RF_WADDR}, {59'd0, e.a});
        chk("rf_wdata", RF_WDATA, e.d);
      end
    end
  end

  initial begin
    RST = 1'b1;
    CSR_REQ_READY = 1'b0; CSR_RDATA = '0; TRAP_ACK = 1'b0; TRAP_VECTOR = '0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    @(negedge CLK);
    chk("rst_instret", INSTRET, 64'd0);
    chk("rst_lock", {63'd0, PIPE_LOCK}, 64'd0);
    chk("rst_redirect_pc", {24'd0, REDIRECT_PC}, 64'd0);
    chk("rst_trap_epc", {24'd0, TRAP_EPC}, 64'd0);
    nxt();
    RST = 1'b0;

    // ALU write to x5
    drive(1, 40'h100, 32'h0, 1, 64'h1234, 5'd5, 0, 0, 0, 0);
    push(5'd5, 64'h1234);
    @(negedge CLK);
    chk("alu_rf_we", {63'd0, RF_WE}, 64'd1);
    chk("alu_lock", {63'd0, PIPE_LOCK}, 64'd0);
    chk("alu_instret_before", INSTRET, exp_ir);
    nxt(); exp_ir++;

    // write to x0 is suppressed but retires
    drive(1, 40'h104, 32'h0, 1, 64'hdead, 5'd0, 0, 0, 0, 0);
    @(negedge CLK);
    chk("alu_instret_after", INSTRET, exp_ir);
    chk("x0_rf_we", {63'd0, RF_WE}, 64'd0);
    nxt(); exp_ir++;

    // WE_WB=0 retires without a write
    drive(1, 40'h108, 32'h0, 0, 64'h77, 5'd7, 0, 0, 0, 0);
    @(negedge CLK);
    chk("x0_instret", INSTRET, exp_ir);
    chk("nowe_rf_we", {63'd0, RF_WE}, 64'd0);
    nxt(); exp_ir++;

    // bubble
    drive(0, 40'h10c, 32'h0, 1, 64'h55, 5'd8, 0, 0, 0, 0);
    @(negedge CLK);
    chk("bubble_instret", INSTRET, exp_ir);
    chk("bubble_rf_waddr", {59'd0, RF_WADDR}, 64'd0);
    chk("bubble_csr_valid", {63'd0, CSR_REQ_VALID}, 64'd0);
    nxt();

    // CSR 0x300, ready after 3 cycles
    drive(1, 40'h110, {12'h300, 8'h00, 5'd9, 7'h73}, 0, 64'h55, 5'd9, 1, 0, 0, 0);
    CSR_RDATA = 64'hAB;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk("csr_wait_lock", {63'd0, PIPE_LOCK}, 64'd1);
      chk("csr_wait_valid", {63'd0, CSR_REQ_VALID}, 64'd1);
      chk("csr_wait_addr", {52'd0, CSR_REQ_ADDR}, 64'h300);
      chk("csr_wait_wdata", CSR_REQ_WDATA, 64'h55);
      chk("csr_wait_instret", INSTRET, exp_ir);
      nxt();
    end
    CSR_REQ_READY = 1'b1;
    push(5'd9, 64'hAB);
    @(negedge CLK);
    chk("csr_done_lock", {63'd0, PIPE_LOCK}, 64'd0);
    chk("csr_done_valid", {63'd0, CSR_REQ_VALID}, 64'd1);
    chk("csr_done_rf_we", {63'd0, RF_WE}, 64'd1);
    nxt(); exp_ir++;
    CSR_REQ_READY = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    chk("csr_instret", INSTRET, exp_ir);
    chk("csr_released", {63'd0, CSR_REQ_VALID}, 64'd0);
    nxt();

    // CSR with ready in the first cycle stays in IDLE
    drive(1, 40'h114, {12'h341, 8'h00, 5'd4, 7'h73}, 0, 64'h9, 5'd4, 1, 0, 0, 0);
    CSR_REQ_READY = 1'b1; CSR_RDATA = 64'h77;
    push(5'd4, 64'h77);
    @(negedge CLK);
    chk("csr0_lock", {63'd0, PIPE_LOCK}, 64'd0);
    chk("csr0_addr", {52'd0, CSR_REQ_ADDR}, 64'h341);
    nxt(); exp_ir++;
    CSR_REQ_READY = 1'b0;
    drive(1, 40'h118, 32'h0, 1, 64'h42, 5'd6, 0, 0, 0, 0);
    push(5'd6, 64'h42);
    @(negedge CLK);
    chk("csr0_instret", INSTRET, exp_ir);
    chk("csr0_idle_after", {63'd0, CSR_REQ_VALID}, 64'd0);
    nxt(); exp_ir++;

    // misaligned load trap, ack on second TRAP_WAIT cycle
    drive(1, 40'h8000, 32'h0, 1, 64'h99, 5'd3, 0, 1, 64'd4, 40'h1003);
    @(negedge CLK);
    chk("xcpt_lock", {63'd0, PIPE_LOCK}, 64'd1);
    chk("xcpt_trap_valid", {63'd0, TRAP_VALID}, 64'd0);
    chk("xcpt_instret", INSTRET, exp_ir);
    nxt();
    @(negedge CLK);
    chk("tw_trap_valid", {63'd0, TRAP_VALID}, 64'd1);
    chk("tw_lock", {63'd0, PIPE_LOCK}, 64'd1);
    chk("tw_cause", TRAP_CAUSE, 64'd4);
    chk("tw_epc", {24'd0, TRAP_EPC}, 64'h8000);
    chk("tw_tval", TRAP_TVAL, 64'h1003);
    nxt();
    TRAP_ACK = 1'b1; TRAP_VECTOR = 40'h100;
    @(negedge CLK);
    chk("tw2_trap_valid", {63'd0, TRAP_VALID}, 64'd1);
    chk("tw2_redirect", {63'd0, REDIRECT_VALID}, 64'd0);
    nxt();
    TRAP_ACK = 1'b0; TRAP_VECTOR = 40'h0;
    @(negedge CLK);
    chk("rd_redirect_valid", {63'd0, REDIRECT_VALID}, 64'd1);
    chk("rd_flush", {63'd0, PIPE_FLUSH}, 64'd1);
    chk("rd_lock", {63'd0, PIPE_LOCK}, 64'd0);
    chk("rd_trap_valid", {63'd0, TRAP_VALID}, 64'd0);
    chk("rd_pc", {24'd0, REDIRECT_PC}, 64'h100);
    nxt();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    chk("post_redirect_valid", {63'd0, REDIRECT_VALID}, 64'd0);
    chk("post_flush", {63'd0, PIPE_FLUSH}, 64'd0);
    chk("trap_instret", INSTRET, exp_ir);
    nxt();

    // exception with CSR_EN set: trap wins; cause 8 carries no tval
    drive(1, 40'h9000, {12'h305, 20'h0}, 0, 64'h5, 5'd2, 1, 1, 64'd8, 40'h2222);
    @(negedge CLK);
    chk("xc_lock", {63'd0, PIPE_LOCK}, 64'd1);
    chk("xc_csr_valid", {63'd0, CSR_REQ_VALID}, 64'd0);
    nxt();
    TRAP_ACK = 1'b1; TRAP_VECTOR = 40'h200;
    @(negedge CLK);
    chk("xc_tw_csr_valid", {63'd0, CSR_REQ_VALID}, 64'd0);
    chk("xc_tw_cause", TRAP_CAUSE, 64'd8);
    chk("xc_tw_tval", TRAP_TVAL, 64'd0);
    chk("xc_tw_epc", {24'd0, TRAP_EPC}, 64'h9000);
    nxt();
    TRAP_ACK = 1'b0;
    @(negedge CLK);
    chk("xc_rd_pc", {24'd0, REDIRECT_PC}, 64'h200);
    chk("xc_rd_csr_valid", {63'd0, CSR_REQ_VALID}, 64'd0);
    nxt();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    chk("xc_instret", INSTRET, exp_ir);
    nxt();

    // reset asserted while in CSR_WAIT
    drive(1, 40'h120, {12'h340, 8'h00, 5'd10, 7'h73}, 0, 64'h3, 5'd10, 1, 0, 0, 0);
    @(negedge CLK);
    chk("rcsr_valid", {63'd0, CSR_REQ_VALID}, 64'd1);
    nxt();
    @(negedge CLK);
    chk("rcsr_wait_lock", {63'd0, PIPE_LOCK}, 64'd1);
    nxt();
    RST = 1'b1;
    #2;
    exp_ir = 64'd0;
    chk("rst_mid_csr_valid", {63'd0, CSR_REQ_VALID}, 64'd0);
    chk("rst_mid_lock", {63'd0, PIPE_LOCK}, 64'd0);
    chk("rst_mid_rf_we", {63'd0, RF_WE}, 64'd0);
    chk("rst_mid_instret", INSTRET, exp_ir);
    nxt();
    RST = 1'b0;
    drive(1, 40'h124, 32'h0, 1, 64'hbeef, 5'd11, 0, 0, 0, 0);
    push(5'd11, 64'hbeef);
    @(negedge CLK);
    chk("post_rst_csr_valid", {63'd0, CSR_REQ_VALID}, 64'd0);
    chk("post_rst_rf_we", {63'd0, RF_WE}, 64'd1);
    nxt(); exp_ir++;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    chk("post_rst_instret", INSTRET, exp_ir);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
